// File: rtl/iob_ram_2p_asym_arb_pkg.sv
// Shared types and helpers for the iob_ram_2p_asym_arb slice.
// Policy macro: IOB_RAM_2P_ASYM_ARB_RR_EN (defined: round-robin, undefined: fixed priority).
package iob_ram_2p_asym_arb_pkg;

    typedef enum logic {
        ArbFixed,
        ArbRoundRobin
    } arb_mode_e;

`ifdef IOB_RAM_2P_ASYM_ARB_RR_EN
    localparam arb_mode_e ArbMode = ArbRoundRobin;
`else
    localparam arb_mode_e ArbMode = ArbFixed;
`endif

    // Index width that stays legal for a single requester.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iob_arb_rr.sv
// Single-grant arbiter with a combinational grant; round-robin or fixed priority
// depending on IOB_RAM_2P_ASYM_ARB_RR_EN (via the package ArbMode).
module iob_arb_rr
    import iob_ram_2p_asym_arb_pkg::*;
#(
    parameter int unsigned N = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [N-1:0] req_i,
    output logic [N-1:0] gnt_o,
    input  logic         ack_i
);

    localparam int unsigned PtrW = idx_width(N);

    logic [PtrW-1:0] ptr;
    logic [N-1:0]    req_hi;
    logic [N-1:0]    sel;
    logic [N-1:0]    gnt;
    logic [PtrW-1:0] win_idx;

    // Requests at or above the pointer take precedence; otherwise wrap to the full set.
    always_comb begin
        req_hi = '0;
        for (int unsigned i = 0; i < N; i++) begin
            req_hi[i] = req_i[i] && (i >= 32'(ptr));
        end
        sel = (|req_hi) ? req_hi : req_i;
        gnt = sel & (~sel + N'(1));
        win_idx = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (gnt[i]) begin
                win_idx = PtrW'(i);
            end
        end
    end

    assign gnt_o = rst_i ? '0 : gnt;

    if (ArbMode == ArbRoundRobin) begin : g_rr
        logic [PtrW-1:0] ptr_q;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                ptr_q <= '0;
            end else if (ack_i && (|gnt)) begin
                ptr_q <= (win_idx == PtrW'(N - 1)) ? '0 : win_idx + PtrW'(1);
            end
        end

        assign ptr = ptr_q;
    end else begin : g_fixed
        logic unused_sig;
        assign unused_sig = ^{ack_i, clk_i, win_idx};
        assign ptr = '0;
    end

endmodule

// File: rtl/iob_ram_2p_asym_arb.sv
// Shares the write and read ports of an asymmetric 2-port RAM among N_REQ requesters.
// Arbitration policy selected by IOB_RAM_2P_ASYM_ARB_RR_EN.
module iob_ram_2p_asym_arb
    import iob_ram_2p_asym_arb_pkg::*;
#(
    parameter int unsigned N_REQ    = 2,
    parameter int unsigned W_DATA_W = 32,
    parameter int unsigned R_DATA_W = 8,
    parameter int unsigned W_ADDR_W = 8,
    parameter int unsigned R_ADDR_W = 10
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_REQ-1:0]          req_w_valid_i,
    output logic [N_REQ-1:0]          req_w_ready_o,
    input  logic [N_REQ*W_ADDR_W-1:0] req_w_addr_i,
    input  logic [N_REQ*W_DATA_W-1:0] req_w_data_i,
    input  logic [N_REQ-1:0]          req_r_valid_i,
    output logic [N_REQ-1:0]          req_r_ready_o,
    input  logic [N_REQ*R_ADDR_W-1:0] req_r_addr_i,
    output logic [R_DATA_W-1:0]       req_r_data_o,
    output logic [N_REQ-1:0]          req_r_rvalid_o,
    output logic                      w_en_o,
    output logic [W_ADDR_W-1:0]       w_addr_o,
    output logic [W_DATA_W-1:0]       w_data_o,
    output logic                      r_en_o,
    output logic [R_ADDR_W-1:0]       r_addr_o,
    input  logic [R_DATA_W-1:0]       r_data_i
);

    logic [N_REQ-1:0]    w_gnt;
    logic [N_REQ-1:0]    r_gnt;
    logic [N_REQ-1:0]    w_hit;
    logic [N_REQ-1:0]    r_hit;
    logic                w_xfer;
    logic                r_xfer;
    logic [N_REQ-1:0]    rtag_q;
    logic [W_ADDR_W-1:0] w_addr;
    logic [W_DATA_W-1:0] w_data;
    logic [R_ADDR_W-1:0] r_addr;

    iob_arb_rr #(
        .N (N_REQ)
    ) u_w_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (req_w_valid_i),
        .gnt_o (w_gnt),
        .ack_i (w_xfer)
    );

    iob_arb_rr #(
        .N (N_REQ)
    ) u_r_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (req_r_valid_i),
        .gnt_o (r_gnt),
        .ack_i (r_xfer)
    );

    assign w_hit  = req_w_valid_i & w_gnt;
    assign r_hit  = req_r_valid_i & r_gnt;
    assign w_xfer = |w_hit;
    assign r_xfer = |r_hit;

    // One-hot grant makes an OR-mux sufficient; idle ports drive zero.
    always_comb begin
        w_addr = '0;
        w_data = '0;
        r_addr = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (w_hit[i]) begin
                w_addr |= req_w_addr_i[i*W_ADDR_W +: W_ADDR_W];
                w_data |= req_w_data_i[i*W_DATA_W +: W_DATA_W];
            end
            if (r_hit[i]) begin
                r_addr |= req_r_addr_i[i*R_ADDR_W +: R_ADDR_W];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rtag_q <= '0;
        end else begin
            rtag_q <= r_hit;
        end
    end

    assign req_w_ready_o  = w_gnt;
    assign req_r_ready_o  = r_gnt;
    assign w_en_o         = w_xfer;
    assign w_addr_o       = w_addr;
    assign w_data_o       = w_data;
    assign r_en_o         = r_xfer;
    assign r_addr_o       = r_addr;
    // A reset in the response cycle discards the pending read.
    assign req_r_rvalid_o = rst_i ? '0 : rtag_q;
    assign req_r_data_o   = r_data_i;

    w_gnt_onehot : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(w_gnt));
    r_gnt_onehot : assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(r_gnt));
    w_gnt_valid  : assert property (@(posedge clk_i) disable iff (rst_i)
                                    (w_gnt & ~req_w_valid_i) == '0);
    r_gnt_valid  : assert property (@(posedge clk_i) disable iff (rst_i)
                                    (r_gnt & ~req_r_valid_i) == '0);

endmodule

// File: tb/tb_iob_ram_2p_asym_arb.sv
// Randomized bench for iob_ram_2p_asym_arb against a behavioural arbitration/RAM model.
// Follows IOB_RAM_2P_ASYM_ARB_RR_EN to choose the expected policy.
module tb_iob_ram_2p_asym_arb;

    localparam int N  = 2;
    localparam int WD = 32;
    localparam int RD = 8;
    localparam int WA = 8;
    localparam int RA = 10;
    localparam int NCYC = 600;

`ifdef IOB_RAM_2P_ASYM_ARB_RR_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [N-1:0]    w_valid, w_ready, r_valid, r_ready, r_rvalid;
    logic [N*WA-1:0] w_addr_bus;
    logic [N*WD-1:0] w_data_bus;
    logic [N*RA-1:0] r_addr_bus;
    logic [RD-1:0]   r_data_out;
    logic            w_en, r_en;
    logic [WA-1:0]   w_addr;
    logic [WD-1:0]   w_data;
    logic [RA-1:0]   r_addr;
    logic [RD-1:0]   ram_rdata;

    iob_ram_2p_asym_arb #(
        .N_REQ    (N),
        .W_DATA_W (WD),
        .R_DATA_W (RD),
        .W_ADDR_W (WA),
        .R_ADDR_W (RA)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_w_valid_i  (w_valid),
        .req_w_ready_o  (w_ready),
        .req_w_addr_i   (w_addr_bus),
        .req_w_data_i   (w_data_bus),
        .req_r_valid_i  (r_valid),
        .req_r_ready_o  (r_ready),
        .req_r_addr_i   (r_addr_bus),
        .req_r_data_o   (r_data_out),
        .req_r_rvalid_o (r_rvalid),
        .w_en_o         (w_en),
        .w_addr_o       (w_addr),
        .w_data_o       (w_data),
        .r_en_o         (r_en),
        .r_addr_o       (r_addr),
        .r_data_i       (ram_rdata)
    );

    // Asymmetric read-first RAM driven by the DUT's RAM ports.
    logic [WD-1:0] ram [256];
    always @(posedge clk) begin
        if (r_en) ram_rdata <= ram[r_addr[9:2]][8*r_addr[1:0] +: 8];
        if (w_en) ram[w_addr] <= w_data;
    end

    // Model state: byte-addressed shadow updated only from bench stimulus.
    byte unsigned  shadow [1024];
    logic [WA-1:0] st_waddr [N];
    logic [WD-1:0] st_wdata [N];
    logic [RA-1:0] st_raddr [N];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // First asserted requester searching upward from p, wrapping; -1 if none.
    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 0; k < N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            w_addr_bus[i*WA +: WA] = st_waddr[i];
            w_data_bus[i*WD +: WD] = st_wdata[i];
            r_addr_bus[i*RA +: RA] = st_raddr[i];
        end
    endtask

    initial begin
        int            wptr, rptr, ww, rw;
        logic [N-1:0]  exp_rtag;
        logic [RD-1:0] exp_rdata;
        logic [WD-1:0] v;

        wptr = 0;
        rptr = 0;
        exp_rtag = '0;
        exp_rdata = '0;
        for (int a = 0; a < 256; a++) begin
            v = $urandom;
            ram[a] = v;
            for (int b = 0; b < 4; b++) shadow[a*4 + b] = v[8*b +: 8];
        end
        rst = 1'b1;
        w_valid = '1;
        r_valid = '1;
        for (int i = 0; i < N; i++) begin
            st_waddr[i] = WA'($urandom_range(0, 3));
            st_wdata[i] = $urandom;
            st_raddr[i] = RA'($urandom_range(0, 15));
        end
        drive();

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            ww = rst ? -1 : pick(w_valid, wptr);
            rw = rst ? -1 : pick(r_valid, rptr);
            check("w_ready", 64'(w_ready), (ww >= 0) ? 64'(1) << ww : 64'(0));
            check("w_en", 64'(w_en), 64'(ww >= 0));
            check("w_addr", 64'(w_addr), (ww >= 0) ? 64'(st_waddr[ww]) : 64'(0));
            check("w_data", 64'(w_data), (ww >= 0) ? 64'(st_wdata[ww]) : 64'(0));
            check("r_ready", 64'(r_ready), (rw >= 0) ? 64'(1) << rw : 64'(0));
            check("r_en", 64'(r_en), 64'(rw >= 0));
            check("r_addr", 64'(r_addr), (rw >= 0) ? 64'(st_raddr[rw]) : 64'(0));
            check("r_rvalid", 64'(r_rvalid), rst ? 64'(0) : 64'(exp_rtag));
            if (!rst && exp_rtag != '0) check("r_data", 64'(r_data_out), 64'(exp_rdata));

            if (rst) begin
                wptr = 0;
                rptr = 0;
                exp_rtag = '0;
            end else begin
                // Read sees memory before this cycle's write.
                if (rw >= 0) begin
                    exp_rdata = shadow[int'(st_raddr[rw])];
                    exp_rtag = N'(1) << rw;
                    if (RrEn) rptr = (rw + 1) % N;
                end else begin
                    exp_rtag = '0;
                end
                if (ww >= 0) begin
                    for (int b = 0; b < 4; b++) begin
                        shadow[int'(st_waddr[ww])*4 + b] = st_wdata[ww][8*b +: 8];
                    end
                    if (RrEn) wptr = (ww + 1) % N;
                end
            end

            @(posedge clk);
            #1;
            if (cyc + 1 < 3) begin
                rst = 1'b1;
            end else if (cyc + 1 < 7) begin
                rst = 1'b0;
                w_valid = '1;
                r_valid = '0;
                st_waddr[0] = 8'h10;
                st_waddr[1] = 8'h20;
            end else begin
                rst = ($urandom_range(0, 49) == 0);
                for (int i = 0; i < N; i++) begin
                    if (!w_valid[i] || ww == i) begin
                        w_valid[i] = ($urandom_range(0, 9) < 6);
                        st_waddr[i] = WA'($urandom_range(0, 3));
                        st_wdata[i] = $urandom;
                    end else if ($urandom_range(0, 19) == 0) begin
                        w_valid[i] = 1'b0;
                    end
                    if (!r_valid[i] || rw == i) begin
                        r_valid[i] = ($urandom_range(0, 9) < 6);
                        st_raddr[i] = RA'($urandom_range(0, 15));
                    end else if ($urandom_range(0, 19) == 0) begin
                        r_valid[i] = 1'b0;
                    end
                end
            end
            drive();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
